// File: rtl/alu_op_sequencer.sv
// Bus-ALU control sequencer: accepts one reg-to-reg instruction, then sequences operand fetch and writeback.
// Latency: done 4 cycles after the accept cycle (3 for NOT). Backpressure: instr_ready low while an instruction is in flight.
module alu_op_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [15:0]         instr,
    output logic [NUM_REGS-1:0] reg_out_en,
    output logic [NUM_REGS-1:0] reg_in_en,
    output logic                alu_latch1_en,
    output logic                alu_latch2_en,
    output logic [3:0]          alu_ctrl,
    output logic                alu_out_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        EXEC
    } state_t;

    localparam logic [3:0] OP_NOT = 4'd3;

    state_t           state;
    logic [3:0]       op_q;
    logic [SEL_W-1:0] dest_q;
    logic [SEL_W-1:0] srca_q;
    logic [SEL_W-1:0] srcb_q;

    logic [3:0]       in_op;
    logic [SEL_W-1:0] in_dest;
    logic [SEL_W-1:0] in_srca;
    logic [SEL_W-1:0] in_srcb;
    logic             in_legal;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == int'(sel)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic sel_ok(input logic [SEL_W-1:0] sel);
        return int'(sel) < NUM_REGS;
    endfunction

    assign in_op   = instr[15:12];
    assign in_dest = instr[11:8];
    assign in_srca = instr[7:4];
    assign in_srcb = instr[3:0];

    // srcB is a don't-care for NOT, so an out-of-range value there is not an error
    assign in_legal = (in_op != 4'd0) && (in_op <= 4'd7) &&
                      sel_ok(in_dest) && sel_ok(in_srca) &&
                      ((in_op == OP_NOT) || sel_ok(in_srcb));

    // Outputs are registered for the state being entered, so nothing on instr reaches a bus enable combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= '0;
            dest_q        <= '0;
            srca_q        <= '0;
            srcb_q        <= '0;
            instr_ready   <= 1'b0;
            reg_out_en    <= '0;
            reg_in_en     <= '0;
            alu_latch1_en <= 1'b0;
            alu_latch2_en <= 1'b0;
            alu_ctrl      <= '0;
            alu_out_en    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            op_count      <= '0;
        end else begin
            reg_out_en    <= '0;
            reg_in_en     <= '0;
            alu_latch1_en <= 1'b0;
            alu_latch2_en <= 1'b0;
            alu_out_en    <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;

            case (state)
                IDLE: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    alu_ctrl    <= '0;
                    if (instr_valid && instr_ready) begin
                        op_q   <= in_op;
                        dest_q <= in_dest;
                        srca_q <= in_srca;
                        srcb_q <= in_srcb;
                        if (in_legal) begin
                            state         <= FETCH_A;
                            instr_ready   <= 1'b0;
                            busy          <= 1'b1;
                            alu_ctrl      <= in_op;
                            reg_out_en    <= onehot(in_srca);
                            alu_latch1_en <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                FETCH_A: begin
                    if (op_q == OP_NOT) begin
                        state      <= EXEC;
                        alu_out_en <= 1'b1;
                        reg_in_en  <= onehot(dest_q);
                    end else begin
                        state         <= FETCH_B;
                        reg_out_en    <= onehot(srcb_q);
                        alu_latch2_en <= 1'b1;
                    end
                end

                FETCH_B: begin
                    state      <= EXEC;
                    alu_out_en <= 1'b1;
                    reg_in_en  <= onehot(dest_q);
                end

                EXEC: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    alu_ctrl    <= '0;
                    done        <= 1'b1;
                    op_count    <= op_count + 16'd1;
                end

                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    alu_ctrl    <= '0;
                end
            endcase
        end
    end

endmodule
